psum_writeback: RTL and testbench
=================================

// Module: psum_writeback
// PURPOSE
//  Drains the corelet's output FIFO (psum vectors, col lanes x psum_bw) into the psum SRAM.
//  Sits directly downstream of the OFIFO read port and upstream of psum memory.
//  Two modes per job: overwrite (first kernel pass) or read-modify-write accumulate (later passes).
//  Software issues one job (base address, vector count, mode) per pass; the block raises done when the job completes.
// PARAMETERS
//  col      8    lanes per psum vector
//  psum_bw  16   bits per lane (two's complement)
//  addr_bw  11   psum SRAM address width
//  len_bw   11   width of the job vector-count field
// PORTS
//  clk          in   1             clock
//  reset        in   1             asynchronous, active-low reset
//  start        in   1             job start pulse; sampled only in IDLE
//  acc          in   1             sampled with start: 0=overwrite, 1=accumulate
//  base_addr    in   addr_bw       first SRAM address of job; sampled with start
//  len          in   len_bw        number of vectors in job; sampled with start
//  ofifo_valid  in   1             OFIFO head holds a full vector
//  ofifo_out    in   psum_bw*col   OFIFO head data; valid while ofifo_valid=1
//  ofifo_rd     out  1             pop OFIFO head at this clock edge
//  pmem_cen     out  1             SRAM chip enable, active-low
//  pmem_wen     out  1             SRAM write enable, active-low (1=read)
//  pmem_a       out  addr_bw       SRAM address
//  pmem_d       out  psum_bw*col   SRAM write data
//  pmem_q       in   psum_bw*col   SRAM read data; valid one cycle after a read
//  busy         out  1             job in progress
//  done         out  1             one-cycle pulse when job completes
// BEHAVIOUR
//  - States: IDLE, WR, RD, ADD, DONE. Registers: addr, remaining count, mode, hold (psum_bw*col).
//  - Reset (reset=0, async): state=IDLE, all registers=0.
//    Outputs in IDLE: ofifo_rd=0, pmem_cen=1, pmem_wen=1, pmem_a=0, pmem_d=0, busy=0, done=0.
//  - IDLE, start=1: latch base_addr/len/acc.
//    len=0 -> DONE. acc=0 -> WR. acc=1 -> RD.
//  - busy=1 in WR/RD/ADD/DONE. start outside IDLE is ignored.
//  - WR, combinational on ofifo_valid:
//    valid=1 -> ofifo_rd=1, pmem_cen=0, pmem_wen=0, pmem_a=addr, pmem_d=ofifo_out.
//    At the edge: addr++, count--. Go to DONE when count reaches 0. Throughput is 1 vector/cycle.
//    valid=0 -> stall: ofifo_rd=0, pmem_cen=1. No state change.
//  - RD, ofifo_valid=1 -> ofifo_rd=1, pmem_cen=0, pmem_wen=1, pmem_a=addr; hold<=ofifo_out; go to ADD.
//    RD, ofifo_valid=0 -> stall as in WR.
//  - ADD (unconditional, one cycle): pmem_cen=0, pmem_wen=0, pmem_a=addr, pmem_d=hold+pmem_q per lane.
//    Then addr++, count--. Go to DONE if count reaches 0, else RD. Throughput is 1 vector/2 cycles.
//  - Lane add: signed psum_bw + psum_bw, truncated to psum_bw (wraps modulo 2^psum_bw, no saturation).
//  - DONE: done=1 and busy=1 for exactly one cycle, pmem idle; then IDLE.
//    start is not accepted in the DONE cycle.
//  - Address wraps modulo 2^addr_bw (e.g. 0x7FF+1 -> 0x000). count never underflows.
//  - ofifo_rd is never asserted when ofifo_valid=0. Each popped vector produces exactly one SRAM write.
//  - Reset mid-job: immediate return to IDLE. Popped but unwritten data is discarded; no done pulse.
// STRUCTURE
//  - Shared header psum_wb_defs.vh holds the state encodings (localparam, 3-bit) and the
//    active-low SRAM control constants (CEN_ON=0, WEN_WR=0). These are reused by the L0/psum SRAM controllers.
//  - One sub-module, vec_add #(col, psum_bw): combinational per-lane wrapping adder (hold + pmem_q).
//  - FSM, address/count counters and the hold register live in psum_writeback.
// TESTING
//  1. Overwrite job: base=0x010, len=4, ofifo_valid held 1, vectors V0..V3.
//     -> writes to 0x010..0x013 on 4 consecutive cycles; done pulses on cycle 5 after start.
//  2. Accumulate job: SRAM 0x020 = all lanes 5, base=0x020, len=1, FIFO lanes=-3.
//     -> RD then ADD; write of all lanes 2; done one cycle later.
//  3. Wrap and stall: acc=1, lane 0x7FFF+1 -> 0x8000; base=0x7FF, len=2 -> writes 0x7FF then 0x000.
//     Drop ofifo_valid for 3 cycles mid-job -> no pops, pmem_cen=1; resumes with no loss.
//  4. len=0 -> no ofifo_rd, no pmem access, done on the cycle after start.
//     start pulsed while busy -> ignored; the original job completes unchanged.
//  5. Assert reset low during ADD of a 4-vector job.
//     -> all outputs return to IDLE values at once; no done pulse; a new job after release runs correctly.

Source files
------------

// File: rtl/psum_writeback_pkg.sv
// Shared definitions for the psum writeback path: default geometry,
// FSM state encodings and active-low SRAM control levels.
package psum_writeback_pkg;

  localparam int unsigned COL     = 8;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned ADDR_BW = 11;
  localparam int unsigned LEN_BW  = 11;

  // 3-bit encodings, shared with the L0/psum SRAM controllers
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } wb_state_e;

  // SRAM control pins are active-low
  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;
  localparam logic WEN_WR  = 1'b0;
  localparam logic WEN_RD  = 1'b1;

endpackage

// File: rtl/psum_writeback_vec_add.sv
// vec_add: per-lane two's complement adder, result wraps modulo 2^psum_bw.
//  a      in  col*psum_bw  first operand vector
//  b      in  col*psum_bw  second operand vector
//  sum_c  out col*psum_bw  lane-wise a+b (combinational)
module vec_add #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16
) (
  input  logic [col*psum_bw-1:0] a,
  input  logic [col*psum_bw-1:0] b,
  output logic [col*psum_bw-1:0] sum_c
);

  // Truncated two's complement add equals unsigned modular add per lane
  for (genvar i = 0; i < col; i++) begin : g_lane
    assign sum_c[i*psum_bw +: psum_bw] = a[i*psum_bw +: psum_bw] + b[i*psum_bw +: psum_bw];
  end

endmodule

// File: rtl/psum_writeback.sv
// psum_writeback: drains OFIFO psum vectors into the psum SRAM, either
// overwriting (1 vector/cycle) or read-modify-write accumulating
// (1 vector/2 cycles). One job = base address, vector count, mode.
//  clk, reset          clock, async active-low reset
//  start/acc/base_addr/len  job descriptor, sampled only in IDLE
//  ofifo_valid/ofifo_out/ofifo_rd  OFIFO head handshake (pop on rd)
//  pmem_cen/wen/a/d/q  psum SRAM port (active-low controls, q one cycle after read)
//  busy, done          job in progress / one-cycle completion pulse
module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int unsigned col     = COL,
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned addr_bw = ADDR_BW,
  parameter int unsigned len_bw  = LEN_BW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    acc,
  input  logic [addr_bw-1:0]      base_addr,
  input  logic [len_bw-1:0]       len,
  input  logic                    ofifo_valid,
  input  logic [col*psum_bw-1:0]  ofifo_out,
  output logic                    ofifo_rd,
  output logic                    pmem_cen,
  output logic                    pmem_wen,
  output logic [addr_bw-1:0]      pmem_a,
  output logic [col*psum_bw-1:0]  pmem_d,
  input  logic [col*psum_bw-1:0]  pmem_q,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned VEC_BW = col * psum_bw;

  wb_state_e           state_q, state_d;
  logic [addr_bw-1:0]  addr_q, addr_d;
  logic [len_bw-1:0]   cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic [VEC_BW-1:0]   hold_q, hold_d;
  logic [VEC_BW-1:0]   sum_c;
  logic [len_bw-1:0]   cnt_dec_c;

  // Accumulate datapath: popped vector plus current SRAM contents
  vec_add #(
    .col     (col),
    .psum_bw (psum_bw)
  ) u_vec_add (
    .a     (hold_q),
    .b     (pmem_q),
    .sum_c (sum_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, counters and SRAM/OFIFO control
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    hold_d   = hold_q;
    ofifo_rd = 1'b0;
    pmem_cen = CEN_OFF;
    pmem_wen = WEN_RD;
    pmem_a   = '0;
    pmem_d   = '0;
    busy     = 1'b1;
    done     = 1'b0;

    // Saturating decrement so the count can never underflow
    cnt_dec_c = (cnt_q != '0) ? cnt_q - len_bw'(1) : '0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          addr_d = base_addr;
          cnt_d  = len;
          acc_d  = acc;
          if (len == '0) state_d = ST_DONE;
          else if (acc)  state_d = ST_RD;
          else           state_d = ST_WR;
        end
      end

      ST_WR: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          pmem_cen = CEN_ON;
          pmem_wen = WEN_WR;
          pmem_a   = addr_q;
          pmem_d   = ofifo_out;
          addr_d   = addr_q + addr_bw'(1);
          cnt_d    = cnt_dec_c;
          if (cnt_dec_c == '0) state_d = ST_DONE;
        end
      end

      ST_RD: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          pmem_cen = CEN_ON;
          pmem_wen = WEN_RD;
          pmem_a   = addr_q;
          hold_d   = ofifo_out;
          state_d  = ST_ADD;
        end
      end

      ST_ADD: begin
        pmem_cen = CEN_ON;
        pmem_wen = WEN_WR;
        pmem_a   = addr_q;
        pmem_d   = sum_c;
        addr_d   = addr_q + addr_bw'(1);
        cnt_d    = cnt_dec_c;
        if (cnt_dec_c == '0) state_d = ST_DONE;
        else if (acc_q)      state_d = ST_RD;
        else                 state_d = ST_WR;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback with an SRAM model and a write scoreboard.
module tb_psum_writeback;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned LEN_W  = 11;
  localparam int unsigned VEC_W  = 128;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [VEC_W-1:0]  d;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              acc;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              ofifo_valid;
  logic [VEC_W-1:0]  ofifo_out;
  logic              ofifo_rd;
  logic              pmem_cen;
  logic              pmem_wen;
  logic [ADDR_W-1:0] pmem_a;
  logic [VEC_W-1:0]  pmem_d;
  logic [VEC_W-1:0]  pmem_q;
  logic              busy;
  logic              done;

  logic [VEC_W-1:0]  mem [0:2047];
  logic [VEC_W-1:0]  ref_mem [int];
  wr_t               exp_q [$];
  logic [VEC_W-1:0]  vq [$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int done_exp = 0;

  psum_writeback dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .acc         (acc),
    .base_addr   (base_addr),
    .len         (len),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .pmem_cen    (pmem_cen),
    .pmem_wen    (pmem_wen),
    .pmem_a      (pmem_a),
    .pmem_d      (pmem_d),
    .pmem_q      (pmem_q),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // SRAM model: write or registered read when enabled
  always @(posedge clk) begin
    if (!pmem_cen) begin
      if (!pmem_wen) mem[pmem_a] <= pmem_d;
      else           pmem_q <= mem[pmem_a];
    end
  end

  function automatic logic [VEC_W-1:0] splat(input logic [15:0] v);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] vec_of(input int s);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(s * 4099 + i * 313 + 7);
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] add_lanes(input logic [VEC_W-1:0] x, input logic [VEC_W-1:0] y);
    logic [VEC_W-1:0] r;
    logic signed [16:0] t;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      t = 17'($signed(x[i*16 +: 16])) + 17'($signed(y[i*16 +: 16]));
      r[i*16 +: 16] = t[15:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [VEC_W-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
    ref_mem[int'(a)] = d;
  endtask

  // Per-cycle monitor: scoreboard SRAM writes, pop legality, done pulses
  task automatic observe();
    wr_t e;
    if (!pmem_cen && !pmem_wen) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_write: observed write to %0h expected none", pmem_a);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", VEC_W'(pmem_a), VEC_W'(e.a));
        chk("wr_data", pmem_d, e.d);
      end
    end
    chk("rd_needs_valid", VEC_W'(ofifo_rd & ~ofifo_valid), '0);
    if (done) done_seen++;
  endtask

  task automatic mid();
    @(negedge clk);
    observe();
  endtask

  task automatic edge_t();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ctl"}, VEC_W'({ofifo_rd, pmem_cen, pmem_wen, busy, done, pmem_a}),
        VEC_W'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'h000}));
    chk({tag, "_d"}, pmem_d, '0);
  endtask

  task automatic run_wr(input logic [ADDR_W-1:0] base, input logic [VEC_W-1:0] vs [$]);
    start = 1'b1; acc = 1'b0; base_addr = base; len = LEN_W'(vs.size()); ofifo_valid = 1'b0;
    mid(); chk("wr_start_idle", VEC_W'(busy), '0); edge_t();
    start = 1'b0;
    for (int k = 0; k < vs.size(); k++) begin
      ofifo_valid = 1'b1; ofifo_out = vs[k];
      push_wr(ADDR_W'(int'(base) + k), vs[k]);
      mid(); chk("wr_pop", VEC_W'({busy, ofifo_rd, done}), VEC_W'(3'b110)); edge_t();
    end
    ofifo_valid = 1'b0;
    mid(); chk("wr_done", VEC_W'({busy, done, pmem_cen, ofifo_rd}), VEC_W'(4'b1110)); edge_t();
    done_exp++;
    mid(); chk("wr_after_idle", VEC_W'({busy, done}), '0); edge_t();
  endtask

  task automatic acc_vec(input logic [ADDR_W-1:0] a, input logic [VEC_W-1:0] v);
    ofifo_valid = 1'b1; ofifo_out = v;
    push_wr(a, add_lanes(ref_mem[int'(a)], v));
    mid(); chk("acc_rd", VEC_W'({ofifo_rd, pmem_cen, pmem_wen, pmem_a}), VEC_W'({3'b101, a})); edge_t();
    ofifo_valid = 1'b0; ofifo_out = ~v;
    mid(); chk("acc_add", VEC_W'({ofifo_rd, pmem_cen, pmem_wen, busy}), VEC_W'(4'b0001)); edge_t();
  endtask

  task automatic start_acc(input logic [ADDR_W-1:0] base, input int n);
    start = 1'b1; acc = 1'b1; base_addr = base; len = LEN_W'(n); ofifo_valid = 1'b0;
    mid(); chk("acc_start_idle", VEC_W'(busy), '0); edge_t();
    start = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    mid(); chk(tag, VEC_W'({busy, done, pmem_cen, ofifo_rd}), VEC_W'(4'b1110)); edge_t();
    done_exp++;
  endtask

  initial begin
    logic [VEC_W-1:0] p0, a0;
    reset = 1'b1; start = 1'b0; acc = 1'b0; base_addr = '0; len = '0;
    ofifo_valid = 1'b1; ofifo_out = vec_of(99);
    #1 reset = 1'b0;
    edge_t();

    // Reset state, with a valid OFIFO head that must not be popped
    mid(); idle_chk("reset"); edge_t();
    ofifo_valid = 1'b0; reset = 1'b1;
    mid(); idle_chk("post_reset"); edge_t();

    // 1: overwrite job, 4 back-to-back vectors
    vq.delete();
    for (int k = 0; k < 4; k++) vq.push_back(vec_of(1 + k));
    run_wr(11'h010, vq);

    // 2: accumulate 5 + (-3) = 2 on every lane
    vq.delete(); vq.push_back(splat(16'd5));
    run_wr(11'h020, vq);
    start_acc(11'h020, 1);
    ofifo_valid = 1'b1; ofifo_out = splat(16'hFFFD);
    push_wr(11'h020, splat(16'h0002));
    mid(); chk("t2_rd", VEC_W'({ofifo_rd, pmem_cen, pmem_wen, pmem_a}), VEC_W'({3'b101, 11'h020})); edge_t();
    ofifo_valid = 1'b0; ofifo_out = '0;
    mid(); chk("t2_add", VEC_W'({ofifo_rd, pmem_cen, pmem_wen, done}), VEC_W'(4'b0000)); edge_t();
    finish_job("t2_done");

    // 3: lane wrap 0x7FFF+1, address wrap 0x7FF -> 0x000, mid-job stall
    p0 = vec_of(5); p0[15:0] = 16'h0001;
    vq.delete(); vq.push_back(p0); vq.push_back(vec_of(6));
    run_wr(11'h7FF, vq);
    start_acc(11'h7FF, 2);
    a0 = vec_of(7); a0[15:0] = 16'h7FFF;
    ofifo_valid = 1'b1; ofifo_out = a0;
    push_wr(11'h7FF, add_lanes(ref_mem[int'(11'h7FF)], a0));
    mid(); chk("t3_rd", VEC_W'({ofifo_rd, pmem_a}), VEC_W'({1'b1, 11'h7FF})); edge_t();
    ofifo_valid = 1'b0;
    mid(); chk("t3_wrap_lane0", VEC_W'(pmem_d[15:0]), VEC_W'(16'h8000)); edge_t();
    for (int k = 0; k < 3; k++) begin
      mid(); chk("t3_stall", VEC_W'({ofifo_rd, pmem_cen, busy, done}), VEC_W'(4'b0110)); edge_t();
    end
    acc_vec(11'h000, vec_of(8));
    finish_job("t3_done");

    // 4: zero-length job, then start pulses while busy and during DONE
    start = 1'b1; acc = 1'b0; base_addr = 11'h030; len = '0;
    ofifo_valid = 1'b1; ofifo_out = vec_of(9);
    mid(); chk("len0_start", VEC_W'({ofifo_rd, pmem_cen}), VEC_W'(2'b01)); edge_t();
    start = 1'b0;
    mid(); chk("len0_done", VEC_W'({done, busy, ofifo_rd, pmem_cen}), VEC_W'(4'b1101)); edge_t();
    done_exp++;
    ofifo_valid = 1'b0;
    mid(); idle_chk("len0_after"); edge_t();

    start = 1'b1; acc = 1'b0; base_addr = 11'h040; len = 11'd3;
    mid(); edge_t();
    base_addr = 11'h050; len = 11'd1; acc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ofifo_valid = 1'b1; ofifo_out = vec_of(20 + k);
      push_wr(ADDR_W'(11'h040 + k), vec_of(20 + k));
      mid(); chk("busy_start_pop", VEC_W'({busy, ofifo_rd}), VEC_W'(2'b11)); edge_t();
    end
    ofifo_valid = 1'b0;
    finish_job("busy_start_done");
    start = 1'b0;
    mid(); chk("busy_start_idle", VEC_W'({busy, done}), '0); edge_t();

    // 5: reset during ADD of a 4-vector accumulate job
    vq.delete();
    for (int k = 0; k < 4; k++) vq.push_back(vec_of(30 + k));
    run_wr(11'h100, vq);
    start_acc(11'h100, 4);
    acc_vec(11'h100, vec_of(40));
    ofifo_valid = 1'b1; ofifo_out = vec_of(41);
    mid(); chk("t5_rd", VEC_W'({ofifo_rd, pmem_a}), VEC_W'({1'b1, 11'h101})); edge_t();
    ofifo_valid = 1'b0;
    reset = 1'b0;
    mid(); idle_chk("t5_reset_add"); edge_t();
    mid(); idle_chk("t5_reset_hold"); edge_t();
    reset = 1'b1;
    mid(); idle_chk("t5_release"); edge_t();
    vq.delete(); vq.push_back(vec_of(50)); vq.push_back(vec_of(51));
    run_wr(11'h200, vq);
    // 0x101 must still hold its pre-job value
    start_acc(11'h101, 1);
    acc_vec(11'h101, vec_of(60));
    finish_job("t5_acc_done");

    chk("done_count", VEC_W'(done_seen), VEC_W'(done_exp));
    chk("sb_empty", VEC_W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
